// File: rtl/data_mem_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_pipe
//   Single-port word memory with a fixed-latency request/response handshake
//   and a hardware clear sequence after reset.
//
//   After RESET the array is cleared one word per cycle (INIT, InitBusy=1).
//   A request is accepted on a rising edge with Req=1 and Ready=1. The access
//   then spends LATENCY-1 cycles in WAIT and one cycle in RESP. A write
//   commits on the edge that enters RESP. During RESP, RValid=1 and ReadData
//   holds the word: the stored word for a read, or the post-write word for a
//   write. Out-of-range accesses (Address >= 4*DEPTH) never touch the array
//   and return 0.
//
//   Optional feature, macro DATAMEM_ALIGN_CHK_EN:
//     An access is suppressed when it is misaligned (Address[1:0] != 0) or
//     out of range, and Err=1 is raised during its RESP. Without the macro,
//     Address[1:0] is ignored and Err is always 0.
//
// Parameters: DATA_W (bits, multiple of 8), DEPTH (words, power of two),
//             LATENCY (1..8 cycles, accept to response)
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   Req, WE           request strobe, 1=write / 0=read
//   Address[31:0]     byte address, word index = Address[log2(DEPTH)+1:2]
//   WD, ByteEn        write data, per-byte write enable
//   Ready             request can be accepted this cycle
//   RValid            one-cycle completion pulse
//   ReadData          response word (0 while RValid=0)
//   InitBusy          clear sequence running
//   Err               access error (0 while RValid=0)
// -----------------------------------------------------------------------------
module data_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Req,
    input  logic                WE,
    input  logic [31:0]         Address,
    input  logic [DATA_W-1:0]   WD,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic                Ready,
    output logic                RValid,
    output logic [DATA_W-1:0]   ReadData,
    output logic                InitBusy,
    output logic                Err
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              NB        = DATA_W / 8;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [2:0]      WAIT_LAST = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [AW-1:0]       r_init_idx;
    logic [2:0]          r_wait_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [31:0]         r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wd;
    logic [NB-1:0]       r_be;

    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_enter_resp;
    logic [31:0]         w_src_addr;
    logic                w_src_we;
    logic [DATA_W-1:0]   w_src_wd;
    logic [NB-1:0]       w_src_be;
    logic [AW-1:0]       w_src_idx;
    logic                w_src_oor;
    logic                w_src_bad;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_new;

    assign Ready    = (r_state == S_IDLE) || (r_state == S_RESP);
    assign InitBusy = (r_state == S_INIT);
    assign RValid   = r_rvalid;
    assign ReadData = r_rdata;
    assign Err      = r_err;

    assign w_accept     = Req && Ready;
    assign w_enter_resp = (w_next_state == S_RESP);

    // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
    // access is served straight from the ports; otherwise from the capture regs.
    assign w_src_addr = (LATENCY == 1) ? Address : r_addr;
    assign w_src_we   = (LATENCY == 1) ? WE      : r_we;
    assign w_src_wd   = (LATENCY == 1) ? WD      : r_wd;
    assign w_src_be   = (LATENCY == 1) ? ByteEn  : r_be;

    assign w_src_idx  = w_src_addr[AW+1:2];
    assign w_src_oor  = |w_src_addr[31:AW+2];

`ifdef DATAMEM_ALIGN_CHK_EN
    assign w_src_bad  = w_src_oor || (w_src_addr[1:0] != 2'b00);
`else
    logic w_unused_addr;
    assign w_unused_addr = |w_src_addr[1:0];
    assign w_src_bad  = w_src_oor;
`endif

    // A read merges with no bytes enabled, giving the stored word unchanged.
    assign w_old = r_mem[w_src_idx];
    assign w_new = f_merge(w_old, w_src_wd, w_src_we ? w_src_be : {NB{1'b0}});

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT: begin
                if (r_init_idx == LAST_IDX) w_next_state = S_IDLE;
                else                        w_next_state = S_INIT;
            end
            S_IDLE, S_RESP: begin
                if (w_accept) w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                else          w_next_state = S_IDLE;
            end
            S_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) w_next_state = S_RESP;
                else                         w_next_state = S_WAIT;
            end
            default: w_next_state = S_INIT;
        endcase
    end

    // State, clear index, wait counter and registered response outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_INIT;
            r_init_idx <= '0;
            r_wait_cnt <= 3'd0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_INIT) begin
                r_init_idx <= r_init_idx + AW'(1);
            end
            if (w_accept) begin
                r_wait_cnt <= 3'd0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end
            r_rvalid <= w_enter_resp;
            r_rdata  <= (w_enter_resp && !w_src_bad) ? w_new : '0;
`ifdef DATAMEM_ALIGN_CHK_EN
            r_err    <= w_enter_resp && w_src_bad;
`else
            r_err    <= 1'b0;
`endif
        end
    end

    // Request capture on the accepting edge.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_addr <= Address;
            r_we   <= WE;
            r_wd   <= WD;
            r_be   <= ByteEn;
        end
    end

    // Array port: clear during INIT, commit writes on the edge entering RESP.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == S_INIT) begin
                r_mem[r_init_idx] <= '0;
            end else if (w_enter_resp && w_src_we && !w_src_bad) begin
                r_mem[w_src_idx] <= w_new;
            end
        end
    end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 128: number of words; power of two, 2 to 4096.
REQ-003 SHALL have parameter LATENCY, default 1: accept-to-response delay in cycles; 1 to 8.
REQ-004 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port Req  in  1  access request.
REQ-007 SHALL have port WE  in  1  1 = write, 0 = read.
REQ-008 SHALL have port Address  in  32  byte address; word index = Address[log2(DEPTH)+1:2].
REQ-009 SHALL have port WD  in  DATA_W  write data.
REQ-010 SHALL have port ByteEn  in  DATA_W/8  per-byte write enable; bit i gates WD[8i+7:8i].
REQ-011 SHALL have port Ready  out  1  block can accept a request this cycle.
REQ-012 SHALL have port RValid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port ReadData  out  DATA_W  read result, valid while RValid=1.
REQ-014 SHALL have port InitBusy  out  1  memory clear in progress.
REQ-015 SHALL have port Err  out  1  access-error flag, valid while RValid=1.

Function
REQ-016 SHALL implement states INIT, IDLE, WAIT and RESP.
REQ-017 INIT SHALL write zero to one word per cycle, index 0 to DEPTH-1, with InitBusy=1 and Ready=0, then go to IDLE; INIT lasts exactly DEPTH cycles.
REQ-018 Ready SHALL be 1 in IDLE and RESP and 0 in INIT and WAIT.
REQ-019 A request SHALL be accepted on an edge where Req=1 and Ready=1.
REQ-020 On accept, the block SHALL capture Address, WE, WD and ByteEn.
REQ-021 Req SHALL be ignored when Ready=0; there is no queuing.
REQ-022 After accept the block SHALL spend LATENCY-1 cycles in WAIT (skipped for LATENCY=1) and then one cycle in RESP with RValid=1.
REQ-023 RValid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-024 A write SHALL commit to the array on the edge entering RESP, updating only bytes whose ByteEn bit is 1; ByteEn=0 SHALL leave the word unchanged.
REQ-025 A read SHALL present the stored word on ReadData during RESP.
REQ-026 For a write, ReadData in RESP SHALL be the word value after the write.
REQ-027 ReadData SHALL be 0 whenever RValid=0.
REQ-028 A request accepted in RESP SHALL be handled as a new access; back-to-back throughput is one access per LATENCY cycles.
REQ-029 A read accepted in RESP for the address being written in that RESP SHALL return the new data.
REQ-030 An access with Address >= 4*DEPTH SHALL be out of range: no array write, ReadData=0 in RESP, RValid still pulses.
REQ-031 Err SHALL be 0 whenever RValid=0.

Reset
REQ-032 While RESET=1 at an edge, the block SHALL set state to INIT, clear-index to 0, Ready=0, RValid=0, ReadData=0 and Err=0, and InitBusy SHALL be 1 from the following cycle.
REQ-033 RESET during WAIT or RESP SHALL abort the pending access; a pending write SHALL NOT commit.
REQ-034 RESET during INIT SHALL restart the clear from index 0.

Configuration
REQ-035 With macro DATAMEM_ALIGN_CHK_EN defined, an access with Address[1:0] != 0 or out of range SHALL be suppressed (no write, ReadData=0) and SHALL assert Err=1 during its RESP.
REQ-036 Without DATAMEM_ALIGN_CHK_EN, Address[1:0] SHALL be ignored, out-of-range handling SHALL follow REQ-030, and Err SHALL be tied to 0.

Verification (DATA_W=32, DEPTH=128, LATENCY=2 unless stated)
REQ-037 Release RESET -> InitBusy=1 for 128 cycles, then Ready=1; a read of every word returns 0x00000000.
REQ-038 Write 0x12345678 to 0x8 with ByteEn=0xF, then write 0xAABBCCDD to 0x8 with ByteEn=0x5 -> read of 0x8 returns 0x12BB56DD with RValid exactly 2 cycles after accept.
REQ-039 LATENCY=1, write 0x5 to 0x10 accepted in RESP, followed immediately by a read of 0x10 -> RValid pulses on consecutive cycles and the read returns 0x00000005.
REQ-040 Write 0xFFFFFFFF to 0x200 (out of range) -> RValid=1, ReadData=0, no array word changes, and Err=1 only when DATAMEM_ALIGN_CHK_EN is defined.
REQ-041 With the macro defined, read of 0x6 -> Err=1 and ReadData=0; without the macro -> returns the word at 0x4 with Err=0.
REQ-042 Assert RESET during WAIT of a write of 0x77 to 0x0 -> no RValid, re-INIT completes, and a read of 0x0 returns 0.
